// File: rtl/npc_pkg.sv
// Shared core-wide constants for the register file and its scoreboard.
package npc_pkg;

    localparam int NPC_ADDR_WIDTH = 5;
    localparam int NPC_DATA_WIDTH = 32;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write scoreboard: issue reserves a destination, write-back releases it.
module regfile_scoreboard
    import npc_pkg::*;
#(
    parameter int ADDR_WIDTH = NPC_ADDR_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alloc_en,
    input  logic [ADDR_WIDTH-1:0]      alloc_addr,
    input  logic                       wb_en,
    input  logic [ADDR_WIDTH-1:0]      wb_addr,
    output logic                       alloc_ok,
    output logic [2**ADDR_WIDTH-1:0]   busy_eff,
    output logic [2**ADDR_WIDTH-1:0]   busy_vec
);

    localparam int DEPTH = 2**ADDR_WIDTH;

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_nxt;

    // A same-cycle write-back already counts as released for alloc and read-busy.
    always_comb begin
        busy_eff = busy_q;
        if (wb_en) begin
            busy_eff[wb_addr] = 1'b0;
        end
        busy_eff[0] = 1'b0;
    end

    always_comb begin
        alloc_ok = 1'b0;
        if (!rst && alloc_en) begin
            alloc_ok = (alloc_addr == '0) || !busy_eff[alloc_addr];
        end
    end

    always_comb begin
        busy_nxt = busy_eff;
        if (alloc_ok && (alloc_addr != '0)) begin
            busy_nxt[alloc_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_nxt;
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with x0 hardwired to zero, write-back bypass and a busy-bit scoreboard.
module regfile_sb
    import npc_pkg::*;
#(
    parameter int ADDR_WIDTH = NPC_ADDR_WIDTH,
    parameter int DATA_WIDTH = NPC_DATA_WIDTH,
    parameter int NREAD      = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NREAD*ADDR_WIDTH-1:0]   rd_addr,
    output logic [NREAD*DATA_WIDTH-1:0]   rd_data,
    output logic [NREAD-1:0]              rd_busy,
    input  logic                          alloc_en,
    input  logic [ADDR_WIDTH-1:0]         alloc_addr,
    output logic                          alloc_ok,
    input  logic                          wb_en,
    input  logic [ADDR_WIDTH-1:0]         wb_addr,
    input  logic [DATA_WIDTH-1:0]         wb_data,
    output logic [2**ADDR_WIDTH-1:0]      busy_vec
);

    localparam int DEPTH = 2**ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0]      busy_eff;

    regfile_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .alloc_ok   (alloc_ok),
        .busy_eff   (busy_eff),
        .busy_vec   (busy_vec)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wb_en && (wb_addr != '0)) begin
            mem[wb_addr] <= wb_data;
        end
    end

    for (genvar k = 0; k < NREAD; k++) begin : g_read
        logic [ADDR_WIDTH-1:0] addr;
        assign addr = rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];

        // x0 wins over bypass so a write-back to x0 never leaks onto a read port.
        always_comb begin
            rd_data[k*DATA_WIDTH +: DATA_WIDTH] = mem[addr];
            rd_busy[k] = busy_eff[addr];
            if (addr == '0) begin
                rd_data[k*DATA_WIDTH +: DATA_WIDTH] = '0;
                rd_busy[k] = 1'b0;
            end else if (wb_en && (wb_addr == addr)) begin
                rd_data[k*DATA_WIDTH +: DATA_WIDTH] = wb_data;
            end
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: reset, alloc/wb interplay, bypass, x0 handling, reset mid-operation.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        alloc_en;
    logic [4:0]  alloc_addr;
    logic        alloc_ok;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] busy_vec;

    int checks = 0;
    int failures = 0;

    regfile_sb dut (
        .clk        (clk),
        .rst        (rst),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr),
        .alloc_ok   (alloc_ok),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .busy_vec   (busy_vec)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
        rd_addr = {a1, a0};
    endtask

    initial begin
        rst = 1'b1; alloc_en = 1'b1; alloc_addr = 5'd4;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        set_rd(5'd5, 5'd0);
        step();
        check("alloc_ok_in_reset", {31'd0, alloc_ok}, 32'd0);

        rst = 1'b0; alloc_en = 1'b0;
        #1;
        check("rd0_x5_after_reset", rd_data[31:0], 32'd0);
        check("rd1_x0_after_reset", rd_data[63:32], 32'd0);
        check("busy_after_reset", busy_vec, 32'd0);

        alloc_en = 1'b1; alloc_addr = 5'd3; set_rd(5'd3, 5'd0);
        #1;
        check("alloc_x3_ok", {31'd0, alloc_ok}, 32'd1);
        step();
        check("busy_x3_set", busy_vec, 32'h0000_0008);
        check("alloc_x3_again_rejected", {31'd0, alloc_ok}, 32'd0);
        check("rd_busy_x3", {30'd0, rd_busy}, 32'd1);
        alloc_en = 1'b0;

        wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'hDEAD_BEEF; set_rd(5'd3, 5'd3);
        #1;
        check("bypass_x3_port0", rd_data[31:0], 32'hDEAD_BEEF);
        check("bypass_x3_port1", rd_data[63:32], 32'hDEAD_BEEF);
        check("bypass_x3_not_busy", {30'd0, rd_busy}, 32'd0);
        step();
        wb_en = 1'b0; wb_data = '0;
        #1;
        check("busy_x3_cleared", busy_vec, 32'd0);
        check("array_x3", rd_data[31:0], 32'hDEAD_BEEF);

        alloc_en = 1'b1; alloc_addr = 5'd7;
        step();
        check("busy_x7_set", busy_vec, 32'h0000_0080);
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h12;
        #1;
        check("alloc_wb_x7_ok", {31'd0, alloc_ok}, 32'd1);
        step();
        alloc_en = 1'b0; wb_en = 1'b0; wb_data = '0; set_rd(5'd7, 5'd0);
        #1;
        check("busy_x7_still_set", busy_vec, 32'h0000_0080);
        check("array_x7", rd_data[31:0], 32'h12);
        check("rd_busy_x7", {30'd0, rd_busy}, 32'd1);

        alloc_en = 1'b1; alloc_addr = 5'd0;
        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF; set_rd(5'd0, 5'd0);
        #1;
        check("alloc_x0_ok", {31'd0, alloc_ok}, 32'd1);
        check("x0_no_bypass", rd_data[31:0], 32'd0);
        step();
        alloc_en = 1'b0; wb_en = 1'b0; wb_data = '0;
        #1;
        check("busy_after_x0", busy_vec, 32'h0000_0080);
        check("x0_reads_zero", rd_data[63:32], 32'd0);

        alloc_en = 1'b1; alloc_addr = 5'd5;
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h34; set_rd(5'd7, 5'd5);
        #1;
        check("alloc_x5_wb_x7_ok", {31'd0, alloc_ok}, 32'd1);
        step();
        alloc_en = 1'b0; wb_en = 1'b0; wb_data = '0;
        #1;
        check("busy_x5_only", busy_vec, 32'h0000_0020);
        check("array_x7_new", rd_data[31:0], 32'h34);
        check("rd_busy_x5_port1", {30'd0, rd_busy}, 32'd2);

        alloc_en = 1'b1; alloc_addr = 5'd9;
        step();
        check("busy_x9_set", busy_vec, 32'h0000_0220);
        rst = 1'b1; alloc_addr = 5'd10;
        wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h55; set_rd(5'd9, 5'd7);
        #1;
        check("alloc_ok_reset_mid", {31'd0, alloc_ok}, 32'd0);
        step();
        rst = 1'b0; alloc_en = 1'b0; wb_en = 1'b0; wb_data = '0;
        #1;
        check("busy_after_mid_reset", busy_vec, 32'd0);
        check("x9_after_reset", rd_data[31:0], 32'd0);
        check("x7_after_reset", rd_data[63:32], 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, register index width (depth 2**ADDR_WIDTH).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, register data width.
REQ-003 SHALL have parameter NREAD, default 2, number of read ports (1..4).
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port rd_addr  input  NREAD*ADDR_WIDTH  packed read indices; port k at bits [k*ADDR_WIDTH +: ADDR_WIDTH].
REQ-007 SHALL have port rd_data  output  NREAD*DATA_WIDTH  packed read data, same packing.
REQ-008 SHALL have port rd_busy  output  NREAD  per-port flag: indexed register has a pending write.
REQ-009 SHALL have port alloc_en  input  1  issue stage reserves a destination register.
REQ-010 SHALL have port alloc_addr  input  ADDR_WIDTH  register to reserve.
REQ-011 SHALL have port alloc_ok  output  1  reservation accepted this cycle.
REQ-012 SHALL have port wb_en  input  1  write-back strobe.
REQ-013 SHALL have port wb_addr  input  ADDR_WIDTH  write-back index.
REQ-014 SHALL have port wb_data  input  DATA_WIDTH  write-back data.
REQ-015 SHALL have port busy_vec  output  2**ADDR_WIDTH  scoreboard state, bit i = register i pending.

Function
REQ-016 SHALL return 0 on every read port whose index is 0, with rd_busy 0, regardless of any writes.
REQ-017 SHALL make reads combinational: rd_data reflects current array contents, with zero-cycle latency.
REQ-018 SHALL bypass: when wb_en=1 and wb_addr equals a nonzero read index, that port returns wb_data in the same cycle.
REQ-019 SHALL write wb_data into the array at posedge when wb_en=1 and wb_addr!=0; writes to index 0 are discarded.
REQ-020 SHALL keep one busy bit per register; bit 0 is constant 0.
REQ-021 SHALL set alloc_ok=1 combinationally when alloc_en=1, alloc_addr!=0 and busy[alloc_addr]=0 (busy bit after same-cycle write-back clear is used, i.e. a wb to the same register makes it allocatable).
REQ-022 SHALL set alloc_ok=1 for alloc_addr=0 when alloc_en=1 and leave busy untouched (x0 never reserved).
REQ-023 SHALL set busy[alloc_addr] at posedge when alloc_ok=1 and alloc_addr!=0.
REQ-024 SHALL clear busy[wb_addr] at posedge when wb_en=1, unless the same register is allocated that cycle, in which case busy ends set.
REQ-025 SHALL leave busy unchanged when wb_en=1 targets a non-busy register; the data write still occurs.
REQ-026 SHALL drive rd_busy[k] from busy after same-cycle write-back clear, so a bypassed value reports not busy.
REQ-027 SHALL treat alloc and wb to different registers in one cycle independently.

Reset
REQ-028 SHALL, while rst=1 at posedge, clear all array entries and all busy bits to 0; alloc and wb in that cycle are ignored.
REQ-029 SHALL force alloc_ok=0 while rst=1; rd_data outputs follow REQ-017/018 (array reads 0 after first reset edge).
REQ-030 SHALL abandon all pending reservations on reset mid-operation; no state survives reset.

Structure
REQ-031 SHALL place default ADDR_WIDTH/DATA_WIDTH constants in shared package npc_pkg; no typedefs required.
REQ-032 SHALL implement the busy-bit logic as one sub-module regfile_scoreboard (alloc/wb/rst in, busy_vec out); data array and bypass stay in regfile_sb.

Verification
REQ-033 SHALL cover: rst pulse, then read x5,x0 -> rd_data 0,0, busy_vec all 0.
REQ-034 SHALL cover: alloc x3 (alloc_ok=1) -> next cycle busy_vec[3]=1; second alloc x3 -> alloc_ok=0.
REQ-035 SHALL cover: wb x3=0xDEADBEEF while reading x3 -> same cycle rd_data=0xDEADBEEF, rd_busy=0; next cycle busy_vec[3]=0, read 0xDEADBEEF.
REQ-036 SHALL cover: alloc x7 and wb x7=0x12 same cycle with x7 busy -> alloc_ok=1, after edge busy[7]=1, array x7=0x12.
REQ-037 SHALL cover: wb x0=0xFFFFFFFF and alloc x0 -> alloc_ok=1, x0 reads 0, busy_vec[0]=0.
REQ-038 SHALL cover: alloc x9, assert rst before wb -> busy_vec all 0, x9 reads 0, alloc_ok=0 during reset.
